// File: rtl/sort_word_demux_loader.sv
`default_nettype none
// ============================================================================
// Module   : sort_word_demux_loader
// Brief    : Scatters a valid/ready word stream into four slot registers and
//            holds the completed frame until the compare/swap stage takes it.
// Revision : 1.0 - initial release
// ============================================================================
module sort_word_demux_loader #(
    parameter int data_in_width = 16,
    parameter bit ZERO_ON_FLUSH = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [data_in_width-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [data_in_width-1:0] q0,
    output logic [data_in_width-1:0] q1,
    output logic [data_in_width-1:0] q2,
    output logic [data_in_width-1:0] q3,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [2:0]               fill_count
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_fill_count;
    logic [data_in_width-1:0] r_slot [4];
    logic                     w_accept;
    logic                     w_release;

    assign in_ready  = (r_state == FILL) & ~flush;
    assign w_accept  = in_valid & in_ready;
    // Flush outranks release, so a frame flushed in HOLD is never handed over.
    assign w_release = (r_state == HOLD) & frame_ready & ~flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL: if (w_accept && r_fill_count == 3'd3) w_state_nxt = HOLD;
                HOLD: if (w_release) w_state_nxt = FILL;
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_count <= 3'd0;
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
        end else if (flush) begin
            r_fill_count <= 3'd0;
            if (ZERO_ON_FLUSH) begin
                for (int i = 0; i < 4; i++) r_slot[i] <= '0;
            end
        end else if (w_accept) begin
            r_slot[r_fill_count[1:0]] <= in_data;
            r_fill_count              <= r_fill_count + 3'd1;
        end else if (w_release) begin
            r_fill_count <= 3'd0;
        end
    end

    assign q0          = r_slot[0];
    assign q1          = r_slot[1];
    assign q2          = r_slot[2];
    assign q3          = r_slot[3];
    assign frame_valid = (r_state == HOLD);
    assign fill_count  = r_fill_count;

endmodule
`default_nettype wire
